// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT/MULTU/DIV/DIVU take 33 cycles (busy E0..E33, done the cycle after); MTHI/MTLO take effect at the next edge.
// Backpressure: start is ignored while busy=1; the core stalls on busy before issuing or reading HI/LO.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  // Shared accumulator: product for multiply, {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig;   // raw rs, returned in HI on divide by zero
  logic               sa;
  logic               sb;
  logic               is_div;
  logic               dz;

  // Operand magnitudes; signed ops take |x|, and 0x80000000 maps to itself as unsigned
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign abs_a = (!op[0] && A[WIDTH-1]) ? -A : A;
  assign abs_b = (!op[0] && B[WIDTH-1]) ? -B : B;

  // Shift-add step: conditionally add multiplicand to the upper half, carry kept for the shift
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  // Restoring step: bring in the next dividend bit and trial-subtract the divisor
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  // Sign correction applied when results are committed
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = (sa ^ sb) ? -acc : acc;
  assign quo_fix  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Control FSM, datapath iteration and HI/LO commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      acc     <= '0;
      opb     <= '0;
      a_orig  <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      is_div  <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b100: HI <= A;
              3'b101: LO <= A;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                sa      <= !op[0] && A[WIDTH-1];
                sb      <= !op[0] && B[WIDTH-1];
                is_div  <= op[1];
                dz      <= (B == '0);
                a_orig  <= A;
                counter <= '0;
                busy    <= 1'b1;
                if (op[1]) begin
                  acc   <= {{WIDTH{1'b0}}, abs_a};
                  opb   <= abs_b;
                  state <= DIV;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, abs_b};
                  opb   <= abs_a;
                  state <= MUL;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc     <= {mul_sum, acc[WIDTH-1:1]};
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) state <= FIX;
        end
        DIV: begin
          if (!div_diff[WIDTH])
            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {HI, LO} <= prod_fix;
          end else if (dz) begin
            LO <= '1;
            HI <= a_orig;
          end else begin
            LO <= quo_fix;
            HI <= rem_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, 33-cycle busy window, done pulse,
// MTHI/MTLO, start-while-busy rejection, async abort and back-to-back issue.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after an edge: present a request, let the next edge (E0) take it, then scramble inputs
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111; A = 32'h5A5A_A5A5; B = 32'h0F0F_F0F0;
  endtask

  // Count edges until busy drops (bounded) and note whether HI/LO moved while busy
  task automatic wait_idle(output int n, output bit held);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = HI; l0 = LO; held = 1'b1; n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (HI !== h0 || LO !== l0) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'b111; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", LO); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int n; bit held;
    start_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_idle(n, held);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 33", n); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hilo_hold got %b exp 1", held); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", done); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h exp ffffffeb", LO); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_clear got %b exp 0", done); end
  endtask

  task automatic test_multu;
    int n; bit held;
    start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n, held);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 33", n); end
    checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", HI); end
    checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", LO); end
    @(posedge clk); #1;
    start_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n, held);
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL mult_m1_hi got %h exp 00000000", HI); end
    checks++; if (LO !== 32'h1) begin errors++; $display("FAIL mult_m1_lo got %h exp 00000001", LO); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int n; bit held;
    start_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n, held);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_busy_cycles got %0d exp 33", n); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL div_hilo_hold got %b exp 1", held); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h exp fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h exp ffffffff", HI); end
    @(posedge clk); #1;
    start_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_idle(n, held);
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo got %h exp fffffffd", LO); end
    checks++; if (HI !== 32'h0000_0001) begin errors++; $display("FAIL div_negb_hi got %h exp 00000001", HI); end
    @(posedge clk); #1;
    start_op(3'b011, 32'h0000_0007, 32'h0000_0000);
    wait_idle(n, held);
    checks++; if (n !== 33) begin errors++; $display("FAIL divu_dz_cycles got %0d exp 33", n); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_dz_lo got %h exp ffffffff", LO); end
    checks++; if (HI !== 32'h0000_0007) begin errors++; $display("FAIL divu_dz_hi got %h exp 00000007", HI); end
    @(posedge clk); #1;
    start_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0000);
    wait_idle(n, held);
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_dz_lo got %h exp ffffffff", LO); end
    checks++; if (HI !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_dz_hi got %h exp fffffff9", HI); end
    @(posedge clk); #1;
    start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n, held);
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", LO); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", HI); end
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo;
    int n;
    logic [31:0] lo0;
    lo0 = LO;
    start = 1'b1; op = 3'b100; A = 32'h1234_5678; B = 32'h0;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", HI); end
    checks++; if (LO !== lo0) begin errors++; $display("FAIL mthi_lo_keep got %h exp %h", LO, lo0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    start = 1'b1; op = 3'b101; A = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    checks++; if (LO !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo got %h exp cafef00d", LO); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_keep got %h exp 12345678", HI); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done got %b exp 0", done); end
    start = 1'b1; op = 3'b110; A = 32'h1111_1111; B = 32'h2;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL noop_ignored got busy=%b hi=%h lo=%h exp busy=0 hi=12345678 lo=cafef00d", busy, HI, LO);
    end
    // MTLO presented while a DIVU 50/6 is in flight must be dropped
    start_op(3'b011, 32'd50, 32'd6);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 3) begin start = 1'b1; op = 3'b101; A = 32'hDEAD_BEEF; end
      else begin start = 1'b0; op = 3'b111; end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 33) begin errors++; $display("FAIL mtlo_busy_cycles got %0d exp 33", n); end
    checks++; if (LO !== 32'd8) begin errors++; $display("FAIL mtlo_busy_lo got %h exp 00000008", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL mtlo_busy_hi got %h exp 00000002", HI); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int n; bit held; int pulses;
    start_op(3'b001, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL abort_hilo got %h_%h exp 0_0", HI, LO); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done); end
    start_op(3'b001, 32'd5, 32'd6);
    wait_idle(n, held);
    pulses = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++; if (LO !== 32'd30) begin errors++; $display("FAIL rerun_lo got %h exp 0000001e", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rerun_hi got %h exp 00000000", HI); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rerun_done_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_ignore_busy;
    int n;
    start_op(3'b011, 32'd100, 32'd7);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 5 || n == 20) begin start = 1'b1; op = 3'b001; A = 32'd3; B = 32'd3; end
      else begin start = 1'b0; op = 3'b111; A = 32'hFFFF_0000 ^ n; B = 32'd1; end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 33) begin errors++; $display("FAIL ignore_busy_cycles got %0d exp 33", n); end
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL ignore_lo got %h exp 0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL ignore_hi got %h exp 00000002", HI); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got busy=%b exp 0", busy); end
  endtask

  task automatic test_back_to_back;
    int n; bit held;
    start_op(3'b000, 32'd6, 32'hFFFF_FFFE);
    wait_idle(n, held);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", done); end
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF4) begin
      errors++; $display("FAIL b2b_first_result got %h_%h exp ffffffff_fffffff4", HI, LO);
    end
    // Issue in the done cycle
    start_op(3'b011, 32'd9, 32'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b exp 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got %b exp 0", done); end
    wait_idle(n, held);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 33", n); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hilo_hold got %b exp 1", held); end
    checks++; if (LO !== 32'd2 || HI !== 32'd1) begin errors++; $display("FAIL b2b_second_result got %h_%h exp 00000001_00000002", HI, LO); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_reset_abort();
    test_ignore_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
